// File: rtl/mau_axil_pkg.sv
// Shared types and constants for the AXI4-Lite memory access unit.
// Holds the FSM state encoding, AXI response codes and a width helper.
package mau_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Number of byte-offset bits for a bus with strb_w byte lanes.
  function automatic int log2_strb(input int strb_w);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < strb_w) r = i + 1;
    end
    return r;
  endfunction

  // EXOKAY counts as success; only SLVERR/DECERR report an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/mau_axil.sv
// AXI4-Lite memory access unit: one outstanding load/store from the core
// to the DCCM slave, with alignment check and zero-strobe short-circuit.
module mau_axil
  import mau_axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int OFS_W = log2_strb(STRB_W);

  state_t state;
  logic   misaligned;
  logic   aw_ok;
  logic   w_ok;

  assign misaligned = (req_addr[OFS_W-1:0] != '0);

  // A channel is finished once its valid has dropped or handshakes this cycle.
  assign aw_ok = !m_axi_awvalid || m_axi_awready;
  assign w_ok  = !m_axi_wvalid  || m_axi_wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      case (state)
        // RESP already shows req_ready, so it can accept exactly like IDLE.
        IDLE, RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
          if (req_valid && req_ready) begin
            req_ready    <= 1'b0;
            m_axi_araddr <= req_addr;
            m_axi_awaddr <= req_addr;
            m_axi_wdata  <= req_wdata;
            m_axi_wstrb  <= req_wstrb;
            if (misaligned) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              req_ready <= 1'b1;
              state     <= RESP;
            end else if (req_write && (req_wstrb == '0)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
              req_ready <= 1'b1;
              state     <= RESP;
            end else if (req_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= resp_is_err(m_axi_rresp);
            rsp_rdata    <= m_axi_rdata;
            req_ready    <= 1'b1;
            state        <= RESP;
          end
        end

        // AW and W retire independently, in either order or together.
        WR_REQ: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= resp_is_err(m_axi_bresp);
            rsp_rdata    <= '0;
            req_ready    <= 1'b1;
            state        <= RESP;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mau_axil.sv
// Self-checking bench for mau_axil: vector table, hand sequences for timing
// and reset corners, and randomized traffic against a transaction-level model.
module tb_mau_axil;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int MAXC   = 100;

  logic              clk;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  mau_axil #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] rdata;
    logic [1:0]      rresp;
    logic [1:0]      bresp;
    int              da;
    int              dw;
    int              drb;
    bit              exp_err;
    logic [DATA_W-1:0] exp_rdata;
    int              exp_lat;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Slave behaviour for the current transaction.
  int              s_ad, s_wd, s_rbd;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]      s_rresp, s_bresp;

  // Observations from the current transaction.
  bit              got_rsp, got_err, ready_at_rsp, early_ready, post_valid, any_valid;
  int              got_lat, n_ar, n_aw, n_w, retract;
  logic [DATA_W-1:0] got_rdata, post_rdata, hs_wdata;
  logic [ADDR_W-1:0] hs_araddr, hs_awaddr;
  logic [STRB_W-1:0] hs_wstrb;
  bit              tr_arv [MAXC];
  bit              tr_rr  [MAXC];
  bit              tr_awv [MAXC];
  bit              tr_wv  [MAXC];
  bit              tr_br  [MAXC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome and completion latency from the
  // request and the slave's response delays.
  function automatic void model(input bit wr, input logic [ADDR_W-1:0] addr,
                                input logic [STRB_W-1:0] wstrb, input logic [DATA_W-1:0] rdata,
                                input logic [1:0] rresp, input logic [1:0] bresp,
                                input int da, input int dw, input int drb,
                                output bit err, output logic [DATA_W-1:0] rd, output int lat);
    if ((addr % STRB_W) != 0) begin
      err = 1'b1; rd = '0; lat = 1;
    end else if (wr && wstrb == '0) begin
      err = 1'b0; rd = '0; lat = 1;
    end else if (!wr) begin
      err = (rresp == 2'b10) || (rresp == 2'b11); rd = rdata; lat = 3 + da + drb;
    end else begin
      err = (bresp == 2'b10) || (bresp == 2'b11); rd = '0;
      lat = 3 + ((da > dw) ? da : dw) + drb;
    end
  endfunction

  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] wstrb);
    int n, ar_c, aw_c, w_c, r_c, b_c;
    bit r_pend, b_pend, b_started, aw_done, w_done;
    bit p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    got_rsp = 0; got_err = 0; got_lat = 0; got_rdata = '0; ready_at_rsp = 0; early_ready = 0;
    any_valid = 0; n_ar = 0; n_aw = 0; n_w = 0; retract = 0;
    hs_araddr = '0; hs_awaddr = '0; hs_wdata = '0; hs_wstrb = '0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    r_pend = 0; b_pend = 0; b_started = 0; aw_done = 0; w_done = 0;
    p_arv = 0; p_arhs = 0; p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0;
    for (int i = 0; i < MAXC; i++) begin
      tr_arv[i] = 0; tr_rr[i] = 0; tr_awv[i] = 0; tr_wv[i] = 0; tr_br[i] = 0;
    end
    for (int k = 1; k < MAXC && !got_rsp; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = STRB_W'($urandom);
      end
      tr_arv[k] = m_axi_arvalid; tr_rr[k] = m_axi_rready; tr_awv[k] = m_axi_awvalid;
      tr_wv[k] = m_axi_wvalid; tr_br[k] = m_axi_bready;
      any_valid |= m_axi_arvalid | m_axi_awvalid | m_axi_wvalid | m_axi_rready | m_axi_bready;
      if ((p_arv && !p_arhs && !m_axi_arvalid) || (p_awv && !p_awhs && !m_axi_awvalid) ||
          (p_wv && !p_whs && !m_axi_wvalid)) retract++;
      // Read data channel, then read address channel.
      if (r_pend) begin
        m_axi_rvalid = (r_c >= s_rbd); r_c++;
        m_axi_rdata = m_axi_rvalid ? s_rdata : $urandom;
        m_axi_rresp = s_rresp;
        if (m_axi_rvalid && m_axi_rready) r_pend = 0;
      end else begin
        m_axi_rvalid = 1'b0; m_axi_rdata = $urandom;
      end
      if (m_axi_arvalid) begin
        m_axi_arready = (ar_c >= s_ad); ar_c++;
        if (m_axi_arready) begin n_ar++; hs_araddr = m_axi_araddr; r_pend = 1; r_c = 0; end
      end else m_axi_arready = 1'b0;
      // Write response, then write address and data channels.
      if (b_pend) begin
        m_axi_bvalid = (b_c >= s_rbd); b_c++; m_axi_bresp = s_bresp;
        if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      end else m_axi_bvalid = 1'b0;
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_c >= s_ad); aw_c++;
        if (m_axi_awready) begin n_aw++; hs_awaddr = m_axi_awaddr; aw_done = 1; end
      end else m_axi_awready = 1'b0;
      if (m_axi_wvalid) begin
        m_axi_wready = (w_c >= s_wd); w_c++;
        if (m_axi_wready) begin n_w++; hs_wdata = m_axi_wdata; hs_wstrb = m_axi_wstrb; w_done = 1; end
      end else m_axi_wready = 1'b0;
      if (aw_done && w_done && !b_started) begin b_pend = 1; b_c = 0; b_started = 1; end
      p_arv = m_axi_arvalid; p_arhs = m_axi_arvalid && m_axi_arready;
      p_awv = m_axi_awvalid; p_awhs = m_axi_awvalid && m_axi_awready;
      p_wv = m_axi_wvalid;   p_whs = m_axi_wvalid && m_axi_wready;
      if (rsp_valid) begin
        got_rsp = 1; got_lat = k; got_err = rsp_err; got_rdata = rsp_rdata; ready_at_rsp = req_ready;
      end else if (req_ready) early_ready = 1;
    end
    chk("rsp_within_budget", got_rsp, 1);
    @(negedge clk);
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    post_valid = rsp_valid;
    post_rdata = rsp_rdata;
  endtask

  task automatic verify(input string tag, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] wstrb,
                        input bit exp_err, input logic [DATA_W-1:0] exp_rdata, input int exp_lat);
    bit short_c;
    short_c = ((addr % STRB_W) != 0) || (wr && wstrb == '0);
    chk({tag, "_latency"}, got_lat, exp_lat);
    chk({tag, "_rsp_err"}, got_err, exp_err);
    chk({tag, "_rsp_rdata"}, got_rdata, exp_rdata);
    chk({tag, "_ready_at_rsp"}, ready_at_rsp, 1);
    chk({tag, "_ready_low_while_busy"}, early_ready, 0);
    chk({tag, "_single_pulse"}, post_valid, 0);
    chk({tag, "_rdata_hold"}, post_rdata, exp_rdata);
    chk({tag, "_valid_retracted"}, retract, 0);
    if (short_c) begin
      chk({tag, "_no_axi_traffic"}, any_valid, 0);
    end else if (!wr) begin
      chk({tag, "_ar_count"}, n_ar, 1);
      chk({tag, "_araddr"}, hs_araddr, addr);
      chk({tag, "_no_write_traffic"}, n_aw + n_w, 0);
    end else begin
      chk({tag, "_aw_count"}, n_aw, 1);
      chk({tag, "_w_count"}, n_w, 1);
      chk({tag, "_awaddr"}, hs_awaddr, addr);
      chk({tag, "_wdata"}, hs_wdata, wdata);
      chk({tag, "_wstrb"}, hs_wstrb, wstrb);
      chk({tag, "_no_read_traffic"}, n_ar, 0);
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    s_ad = v.da; s_wd = v.dw; s_rbd = v.drb;
    s_rdata = v.rdata; s_rresp = v.rresp; s_bresp = v.bresp;
    run_txn(v.wr, v.addr, v.wdata, v.wstrb);
    verify(tag, v.wr, v.addr, v.wdata, v.wstrb, v.exp_err, v.exp_rdata, v.exp_lat);
  endtask

  vec_t vecs [10];

  initial begin
    vec_t rv;
    resetn = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = '0; m_axi_bvalid = 0;

    //            wr  addr       wdata         strb  rdata         rr     br     da dw drb err exp_rdata     lat
    vecs[0] = '{1'b0, 32'h100, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 0, 1'b0, 32'hDEADBEEF, 3};
    vecs[1] = '{1'b1, 32'h204, 32'h12345678, 4'h3, 32'h0,        2'b00, 2'b00, 3, 0, 0, 1'b0, 32'h0,        6};
    vecs[2] = '{1'b0, 32'h80,  32'h0,        4'h0, 32'hA5A5A5A5, 2'b10, 2'b00, 0, 0, 0, 1'b1, 32'hA5A5A5A5, 3};
    vecs[3] = '{1'b1, 32'h80,  32'hCAFEF00D, 4'hF, 32'h0,        2'b00, 2'b11, 0, 0, 0, 1'b1, 32'h0,        3};
    vecs[4] = '{1'b0, 32'h102, 32'h0,        4'h0, 32'h11111111, 2'b00, 2'b00, 0, 0, 0, 1'b1, 32'h0,        1};
    vecs[5] = '{1'b1, 32'h40,  32'h55AA55AA, 4'h0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 1'b0, 32'h0,        1};
    vecs[6] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h0BADF00D, 2'b01, 2'b00, 2, 0, 1, 1'b0, 32'h0BADF00D, 6};
    vecs[7] = '{1'b1, 32'h44,  32'h87654321, 4'hF, 32'h0,        2'b00, 2'b01, 0, 2, 2, 1'b0, 32'h0,        7};
    vecs[8] = '{1'b1, 32'h46,  32'h13572468, 4'hF, 32'h0,        2'b00, 2'b00, 0, 0, 0, 1'b1, 32'h0,        1};
    vecs[9] = '{1'b0, 32'h8,   32'h0,        4'h0, 32'h76543210, 2'b11, 2'b00, 1, 0, 0, 1'b1, 32'h76543210, 4};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    chk("rst_addr_data", {m_axi_araddr, m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
    resetn = 1'b1;
    #1 chk("req_ready_before_first_edge", req_ready, 0);
    @(negedge clk);
    chk("req_ready_after_first_edge", req_ready, 1);

    for (int i = 0; i < 10; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Read timing with an immediate slave.
    apply_vec("t1", vecs[0]);
    chk("t1_arvalid_T1", tr_arv[1], 1);
    chk("t1_arvalid_T2", tr_arv[2], 0);
    chk("t1_rready_T2", tr_rr[2], 1);

    // Write with AW delayed past W.
    apply_vec("t2", vecs[1]);
    chk("t2_wvalid_T1", tr_wv[1], 1);
    chk("t2_wvalid_T2", tr_wv[2], 0);
    chk("t2_awvalid_T4", tr_awv[4], 1);
    chk("t2_awvalid_T5", tr_awv[5], 0);
    chk("t2_bready_T4", tr_br[4], 0);
    chk("t2_bready_T5", tr_br[5], 1);

    // Reset asserted while a read address is pending.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_arvalid_pending", m_axi_arvalid, 1);
    #2 resetn = 1'b0;
    #1 chk("t6_arvalid_async_clear", m_axi_arvalid, 0);
    chk("t6_req_ready_in_reset", req_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("t6_req_ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("t6_req_ready_after_edge", req_ready, 1);
    rv = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h3C3C3C3C, 2'b00, 2'b00, 0, 0, 0, 1'b0, 32'h3C3C3C3C, 3};
    apply_vec("t6_after_reset", rv);

    // Randomized traffic against the transaction model.
    for (int i = 0; i < 40; i++) begin
      logic [ADDR_W-1:0] a;
      rv.wr = 1'($urandom_range(0, 1));
      a = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      rv.addr = a;
      rv.wdata = $urandom;
      rv.wstrb = ($urandom_range(0, 7) == 0) ? '0 : STRB_W'($urandom_range(1, 15));
      rv.rdata = $urandom;
      rv.rresp = 2'($urandom);
      rv.bresp = 2'($urandom);
      rv.da = $urandom_range(0, 3);
      rv.dw = $urandom_range(0, 3);
      rv.drb = $urandom_range(0, 3);
      model(rv.wr, rv.addr, rv.wstrb, rv.rdata, rv.rresp, rv.bresp, rv.da, rv.dw, rv.drb,
            rv.exp_err, rv.exp_rdata, rv.exp_lat);
      apply_vec($sformatf("rnd%0d", i), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
